memory_port_arbiter: RTL and testbench

- Shares one non-pipelined memory port between two requesters: the fetch stage (instruction reads) and the data path (loads/stores from the read/write stages).
- Data requests have priority; a streak counter guarantees fetch forward progress.
- One transaction is outstanding at a time.
- A timeout converts a hung memory access into an error response, so the pipeline's hold logic can never deadlock.

---
 rtl/memory_port_arbiter_pkg.sv | 26 ++
 rtl/memory_port_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_memory_port_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_port_arbiter_pkg.sv
// Shared types and grant policy for the fetch/data memory port arbiter.
package memory_port_arbiter_pkg;

  typedef logic [31:0] regval_t;

  typedef enum logic [1:0] {Idle, Access, Respond} arb_state_t;
  typedef enum logic {OwnerFetch, OwnerData} arb_owner_t;

  localparam int unsigned StreakWidth = 4;
  typedef logic [StreakWidth-1:0] streak_t;

  // Data wins unless the waiting fetch has already been passed over max_streak times.
  function automatic arb_owner_t select_owner(
    input logic    fetch_request,
    input logic    fetch_flush,
    input logic    data_request,
    input streak_t streak,
    input streak_t max_streak
  );
    if (fetch_request && !fetch_flush && (!data_request || streak == max_streak)) begin
      return OwnerFetch;
    end
    return OwnerData;
  endfunction

endpackage

// File: rtl/memory_port_arbiter.sv
// Arbitrates one non-pipelined memory port between instruction fetch and data accesses,
// with a fetch-starvation streak limit and an access timeout that reports bus_error.
module memory_port_arbiter
  import memory_port_arbiter_pkg::*;
#(
  parameter int unsigned MaxDataStreak = 4,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic    clock,
  input  logic    reset,
  input  logic    fetch_request,
  input  regval_t fetch_address,
  input  logic    fetch_flush,
  output logic    fetch_done,
  output regval_t fetch_data,
  input  logic    data_request,
  input  logic    data_is_write,
  input  regval_t data_address,
  input  regval_t data_write_value,
  output logic    data_done,
  output regval_t data_read_value,
  output logic    bus_error,
  output regval_t mem_address,
  output logic    mem_read,
  output logic    mem_write,
  output regval_t mem_write_value,
  input  logic    mem_done,
  input  regval_t mem_read_value
);

  localparam streak_t    MaxStreak    = streak_t'(MaxDataStreak);
  localparam logic [7:0] TimeoutLimit = 8'(TimeoutCycles);

  arb_state_t state_q, state_d;
  arb_owner_t owner_q, owner_d, grant_owner;
  streak_t    streak_q, streak_d;
  logic [7:0] timer_q, timer_d, timer_next;
  logic       error_q, error_d, discard_q, discard_d;
  regval_t    rdata_q, rdata_d;
  regval_t    mem_address_q, mem_address_d, mem_write_value_q, mem_write_value_d;
  regval_t    fetch_data_q, fetch_data_d, data_read_value_q, data_read_value_d;
  logic       mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic       fetch_done_q, fetch_done_d, data_done_q, data_done_d, bus_error_q, bus_error_d;
  logic       grant_valid, fetch_kept;

  always_comb begin
    grant_valid = (fetch_request && !fetch_flush) || data_request;
    grant_owner = select_owner(fetch_request, fetch_flush, data_request, streak_q, MaxStreak);
    timer_next  = timer_q + 8'd1;
    // A flush arriving in Respond still has to cancel the pulse registered at the end of it.
    fetch_kept  = !(discard_q || fetch_flush);
  end

  always_comb begin
    state_d           = state_q;
    owner_d           = owner_q;
    streak_d          = streak_q;
    timer_d           = timer_q;
    error_d           = error_q;
    discard_d         = discard_q;
    rdata_d           = rdata_q;
    mem_address_d     = mem_address_q;
    mem_read_d        = mem_read_q;
    mem_write_d       = mem_write_q;
    mem_write_value_d = mem_write_value_q;
    fetch_data_d      = fetch_data_q;
    data_read_value_d = data_read_value_q;
    fetch_done_d      = 1'b0;
    data_done_d       = 1'b0;
    bus_error_d       = 1'b0;

    case (state_q)
      Idle: begin
        if (grant_valid) begin
          state_d   = Access;
          owner_d   = grant_owner;
          timer_d   = '0;
          error_d   = 1'b0;
          discard_d = 1'b0;
          rdata_d   = '0;
          if (grant_owner == OwnerFetch) begin
            mem_address_d     = fetch_address;
            mem_read_d        = 1'b1;
            mem_write_d       = 1'b0;
            mem_write_value_d = '0;
            streak_d          = '0;
          end else begin
            mem_address_d     = data_address;
            mem_read_d        = !data_is_write;
            mem_write_d       = data_is_write;
            mem_write_value_d = data_is_write ? data_write_value : '0;
            if (!fetch_request) begin
              streak_d = '0;
            end else if (streak_q != MaxStreak) begin
              streak_d = streak_q + 4'd1;
            end
          end
        end
      end
      Access: begin
        timer_d = timer_next;
        if (owner_q == OwnerFetch && fetch_flush) begin
          discard_d = 1'b1;
        end
        // mem_done takes precedence over a timeout landing in the same cycle.
        if (mem_done) begin
          rdata_d     = mem_write_q ? '0 : mem_read_value;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = Respond;
        end else if (timer_next == TimeoutLimit) begin
          rdata_d     = '0;
          error_d     = 1'b1;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = Respond;
        end
      end
      Respond: begin
        state_d = Idle;
        if (owner_q == OwnerFetch) begin
          if (fetch_kept) begin
            fetch_done_d = 1'b1;
            fetch_data_d = rdata_q;
            bus_error_d  = error_q;
          end
        end else begin
          data_done_d       = 1'b1;
          data_read_value_d = rdata_q;
          bus_error_d       = error_q;
        end
      end
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q           <= Idle;
      owner_q           <= OwnerFetch;
      streak_q          <= '0;
      timer_q           <= '0;
      error_q           <= 1'b0;
      discard_q         <= 1'b0;
      rdata_q           <= '0;
      mem_address_q     <= '0;
      mem_read_q        <= 1'b0;
      mem_write_q       <= 1'b0;
      mem_write_value_q <= '0;
      fetch_data_q      <= '0;
      data_read_value_q <= '0;
      fetch_done_q      <= 1'b0;
      data_done_q       <= 1'b0;
      bus_error_q       <= 1'b0;
    end else begin
      state_q           <= state_d;
      owner_q           <= owner_d;
      streak_q          <= streak_d;
      timer_q           <= timer_d;
      error_q           <= error_d;
      discard_q         <= discard_d;
      rdata_q           <= rdata_d;
      mem_address_q     <= mem_address_d;
      mem_read_q        <= mem_read_d;
      mem_write_q       <= mem_write_d;
      mem_write_value_q <= mem_write_value_d;
      fetch_data_q      <= fetch_data_d;
      data_read_value_q <= data_read_value_d;
      fetch_done_q      <= fetch_done_d;
      data_done_q       <= data_done_d;
      bus_error_q       <= bus_error_d;
    end
  end

  assign mem_address     = mem_address_q;
  assign mem_read        = mem_read_q;
  assign mem_write       = mem_write_q;
  assign mem_write_value = mem_write_value_q;
  assign fetch_done      = fetch_done_q;
  assign fetch_data      = fetch_data_q;
  assign data_done       = data_done_q;
  assign data_read_value = data_read_value_q;
  assign bus_error       = bus_error_q;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Bench for memory_port_arbiter: directed scenarios then random traffic, checked every cycle
// against a transaction-level schedule model (grant cycle, access length, done cycle).
module tb_memory_port_arbiter;

  localparam int MAXS = 4;
  localparam int TMO  = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        fetch_request, fetch_flush, fetch_done;
  logic [31:0] fetch_address, fetch_data;
  logic        data_request, data_is_write, data_done;
  logic [31:0] data_address, data_write_value, data_read_value;
  logic        bus_error, mem_read, mem_write, mem_done;
  logic [31:0] mem_address, mem_write_value, mem_read_value;

  memory_port_arbiter #(.MaxDataStreak(MAXS), .TimeoutCycles(TMO)) dut (
    .clock(clock), .reset(reset),
    .fetch_request(fetch_request), .fetch_address(fetch_address), .fetch_flush(fetch_flush),
    .fetch_done(fetch_done), .fetch_data(fetch_data),
    .data_request(data_request), .data_is_write(data_is_write), .data_address(data_address),
    .data_write_value(data_write_value), .data_done(data_done), .data_read_value(data_read_value),
    .bus_error(bus_error), .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_write_value(mem_write_value), .mem_done(mem_done), .mem_read_value(mem_read_value)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          valid;
    bit          fetch;
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          g;
    int          a;
    bit          err;
    bit          discard;
  } txn_t;

  int nchecks = 0;
  int nerrors = 0;
  int cyc = 0;

  txn_t        cur;
  int          streak_m = 0;
  int          free_at = 0;
  int          lat_cur = 1;
  logic [31:0] rdata_cur = '0;
  int          scount = 0;

  bit          rand_lat = 0, auto_f = 0, auto_d = 0, b2b_d = 0;
  int          fixed_lat = 1, flush_pct = 0;
  logic [31:0] fixed_rdata = '0;

  int          cnt_fd = 0, cnt_dd = 0, cnt_rd = 0;
  int          last_fd_cyc = 0, last_dd_cyc = 0;
  logic [31:0] last_dd_val = '0;
  logic        last_dd_err = 1'b0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrors++;
      $error("FAIL %s at cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrors++;
      $error("FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic new_data_req();
    data_address     = $urandom & 32'hFFFF_FFFC;
    data_is_write    = 1'($urandom_range(0, 1));
    data_write_value = $urandom;
    data_request     = 1'b1;
  endtask

  task automatic new_fetch_req();
    fetch_address = $urandom & 32'hFFFF_FFFC;
    fetch_request = 1'b1;
  endtask

  // Applies the spec's grant rules to the inputs that the coming edge will sample.
  task automatic model_commit();
    bit fg;
    if (cur.valid && cur.fetch && fetch_flush && cyc > cur.g && cyc <= cur.g + cur.a + 1)
      cur.discard = 1'b1;
    if (reset) begin
      cur.valid = 1'b0;
      streak_m  = 0;
      free_at   = cyc + 1;
    end else if (cyc >= free_at) begin
      fg = fetch_request && !fetch_flush && (!data_request || streak_m == MAXS);
      if (fg || data_request) begin
        cur.valid   = 1'b1;
        cur.fetch   = fg;
        cur.write   = fg ? 1'b0 : data_is_write;
        cur.addr    = fg ? fetch_address : data_address;
        cur.wdata   = data_write_value;
        cur.g       = cyc;
        cur.discard = 1'b0;
        if (fg) streak_m = 0;
        else if (fetch_request) streak_m = (streak_m < MAXS) ? streak_m + 1 : MAXS;
        else streak_m = 0;
        lat_cur   = rand_lat ? int'($urandom_range(0, 10)) : fixed_lat;
        rdata_cur = rand_lat ? $urandom : fixed_rdata;
        cur.rdata = rdata_cur;
        cur.err   = !(lat_cur >= 1 && lat_cur <= TMO);
        cur.a     = cur.err ? TMO : lat_cur;
        free_at   = cyc + cur.a + 2;
      end
    end
  endtask

  task automatic check_cycle();
    bit in_acc, done_c;
    in_acc = cur.valid && cyc > cur.g && cyc <= cur.g + cur.a;
    done_c = cur.valid && cyc == cur.g + cur.a + 2;
    chk1("mem_read", mem_read, in_acc && !cur.write);
    chk1("mem_write", mem_write, in_acc && cur.write);
    if (in_acc) chk("mem_address", mem_address, cur.addr);
    if (in_acc && cur.write) chk("mem_write_value", mem_write_value, cur.wdata);
    chk1("fetch_done", fetch_done, done_c && cur.fetch && !cur.discard);
    chk1("data_done", data_done, done_c && !cur.fetch);
    chk1("bus_error", bus_error, done_c && !(cur.fetch && cur.discard) && cur.err);
    if (done_c && !cur.fetch)
      chk("data_read_value", data_read_value, (cur.err || cur.write) ? 32'h0 : cur.rdata);
    if (done_c && cur.fetch && !cur.discard)
      chk("fetch_data", fetch_data, cur.err ? 32'h0 : cur.rdata);
    chk1("one_done", fetch_done && data_done, 1'b0);
    chk1("one_strobe", mem_read && mem_write, 1'b0);
    if (fetch_done === 1'b1) begin cnt_fd++; last_fd_cyc = cyc; end
    if (data_done === 1'b1) begin
      cnt_dd++; last_dd_cyc = cyc; last_dd_val = data_read_value; last_dd_err = bus_error;
    end
    if (mem_read === 1'b1) cnt_rd++;
  endtask

  task automatic agents_and_memory();
    if (fetch_done === 1'b1) fetch_request = 1'b0;
    if (data_done === 1'b1) begin
      if (b2b_d) new_data_req();
      else data_request = 1'b0;
    end
    if (fetch_flush) begin fetch_flush = 1'b0; fetch_request = 1'b0; end
    if (auto_f && !fetch_request && $urandom_range(0, 3) == 0) new_fetch_req();
    if (auto_d && !data_request && $urandom_range(0, 3) == 0) new_data_req();
    if (auto_f && fetch_request && int'($urandom_range(0, 99)) < flush_pct) fetch_flush = 1'b1;
    if (mem_read === 1'b1 || mem_write === 1'b1) scount++;
    else scount = 0;
    mem_done       = (lat_cur != 0 && scount == lat_cur);
    mem_read_value = mem_done ? rdata_cur : $urandom;
  endtask

  task automatic step();
    model_commit();
    @(posedge clock);
    #1;
    cyc++;
    check_cycle();
    agents_and_memory();
  endtask

  task automatic wait_done(input string tag, input bit want_fetch, input int budget);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      step();
      n++;
      seen = want_fetch ? (fetch_done === 1'b1) : (data_done === 1'b1);
    end
    chk1({tag, "_done_seen"}, seen, 1'b1);
  endtask

  task automatic clear_counts();
    cnt_fd = 0; cnt_dd = 0; cnt_rd = 0;
  endtask

  initial begin
    int g0;
    cur = '{default: 0};
    reset = 1'b1;
    fetch_request = 1'b0; fetch_flush = 1'b0; fetch_address = '0;
    data_request = 1'b0; data_is_write = 1'b0; data_address = '0; data_write_value = '0;
    mem_done = 1'b0; mem_read_value = '0;
    step(); step();
    chk("rst_mem_address", mem_address, 32'h0);
    chk("rst_mem_write_value", mem_write_value, 32'h0);
    chk("rst_fetch_data", fetch_data, 32'h0);
    chk("rst_data_read_value", data_read_value, 32'h0);
    reset = 1'b0;
    step();

    // Zero-wait load
    clear_counts();
    fixed_lat = 1; fixed_rdata = 32'hDEAD_BEEF;
    data_address = 32'h100; data_is_write = 1'b0; data_request = 1'b1;
    g0 = cyc;
    wait_done("load", 1'b0, 20);
    chk("load_latency", 32'(last_dd_cyc - g0), 32'd3);
    chk("load_value", last_dd_val, 32'hDEAD_BEEF);
    chk("load_read_cycles", 32'(cnt_rd), 32'd1);
    step();

    // Simultaneous fetch and store: data first
    clear_counts();
    fixed_rdata = 32'h0000_0013;
    fetch_address = 32'h40; fetch_request = 1'b1;
    data_address = 32'h200; data_is_write = 1'b1; data_write_value = 32'h1234; data_request = 1'b1;
    wait_done("simul", 1'b1, 30);
    chk("simul_data_dones", 32'(cnt_dd), 32'd1);
    chk1("simul_fetch_after_data", last_fd_cyc > last_dd_cyc, 1'b1);
    step();

    // Streak limit with back-to-back data traffic
    clear_counts();
    fixed_lat = 2; b2b_d = 1'b1;
    new_data_req();
    fetch_address = 32'h80; fetch_request = 1'b1;
    wait_done("streak1", 1'b1, 100);
    chk("streak_first", 32'(cnt_dd), 32'd4);
    cnt_dd = 0;
    fetch_address = 32'h84; fetch_request = 1'b1;
    wait_done("streak2", 1'b1, 100);
    chk("streak_restart", 32'(cnt_dd), 32'd4);
    b2b_d = 1'b0;
    wait_done("streak_drain", 1'b0, 50);
    step();

    // Flush during Access
    clear_counts();
    fixed_lat = 5;
    fetch_address = 32'hC0; fetch_request = 1'b1;
    step(); step();
    fetch_flush = 1'b1;
    repeat (10) step();
    chk("flush_read_cycles", 32'(cnt_rd), 32'd5);
    chk("flush_fetch_dones", 32'(cnt_fd), 32'd0);
    fixed_lat = 1; fixed_rdata = 32'hCAFE_0001;
    data_address = 32'h104; data_is_write = 1'b0; data_request = 1'b1;
    wait_done("post_flush", 1'b0, 20);
    chk("post_flush_value", last_dd_val, 32'hCAFE_0001);
    step();

    // Timeout, then mem_done on the last allowed cycle
    clear_counts();
    fixed_lat = 0;
    data_address = 32'h300; data_is_write = 1'b0; data_request = 1'b1;
    wait_done("timeout", 1'b0, 30);
    chk("timeout_read_cycles", 32'(cnt_rd), 32'd8);
    chk1("timeout_bus_error", last_dd_err, 1'b1);
    chk("timeout_value", last_dd_val, 32'h0);
    step();
    clear_counts();
    fixed_lat = 8; fixed_rdata = 32'h5555_AAAA;
    data_request = 1'b1;
    wait_done("late_done", 1'b0, 30);
    chk("late_read_cycles", 32'(cnt_rd), 32'd8);
    chk1("late_bus_error", last_dd_err, 1'b0);
    chk("late_value", last_dd_val, 32'h5555_AAAA);
    step();

    // Reset during Access, then a clean load
    fixed_lat = 0;
    data_address = 32'h100; data_is_write = 1'b0; data_request = 1'b1;
    step(); step(); step();
    reset = 1'b1;
    step();
    chk("midrst_mem_address", mem_address, 32'h0);
    chk("midrst_data_read_value", data_read_value, 32'h0);
    reset = 1'b0;
    fixed_lat = 1; fixed_rdata = 32'hDEAD_BEEF;
    clear_counts();
    g0 = cyc;
    wait_done("after_reset", 1'b0, 20);
    chk("after_reset_latency", 32'(last_dd_cyc - g0), 32'd3);
    chk("after_reset_value", last_dd_val, 32'hDEAD_BEEF);
    chk("after_reset_read_cycles", 32'(cnt_rd), 32'd1);

    // Random mixed traffic
    rand_lat = 1'b1; auto_f = 1'b1; auto_d = 1'b1; flush_pct = 5;
    repeat (2000) step();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
